tt_um_emern_spi_cmd_tx: RTL
===========================

// Module: tt_um_emern_spi_cmd_tx
// PURPOSE
//  Host-side SPI master for the GPU command link. Packs one command byte plus a 6-byte polygon/colour payload
//  into the 53-bit GPU frame and shifts it out LSB-first (SPI mode 0, write-only), one frame per CS-low window.
//  Sits in the host/test-harness domain; drives the cs/sck/mosi pins of the GPU frontend.
// PARAMETERS
//  HALF_PERIOD  4  clk cycles per SCK half-period; min 2 (the receiver synchronises SCK through 3 flops)
//  CS_SETUP     2  clk cycles CS low before the first SCK low phase begins
//  CS_GAP       4  clk cycles CS held high after a frame before next accept (receiver clears on CS high); min 2
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   frame request
//  cmd_ready  out  1   high only in IDLE; a frame is accepted on a clk edge with cmd_valid & cmd_ready
//  cmd        in   8   command byte (0x80 WR_A, 0x40 CLR_A, 0x81 WR_B, 0x41 CLR_B, 0x01 SET_BG)
//  color      in   6   polygon or background colour
//  v0_x/v1_x/v2_x in 7 each   vertex x
//  v0_y/v1_y/v2_y in 6 each   vertex y
//  window_ok  in   1   high when the GPU accepts bits (HSYNC / display off); gates every SCK rising edge
//  cs_out     out  1   chip select, active low
//  sck_out    out  1   SPI clock, idle low
//  mosi_out   out  1   serial data
//  busy       out  1   ~cmd_ready
//  done       out  1   1-cycle pulse when CS_GAP completes
//  cmd_err    out  1   1-cycle pulse on a rejected command (SPI_TX_CMD_FILTER_EN only; else tied 0)
// BEHAVIOUR
//  Reset: cs_out=1, sck_out=0, mosi_out=0, cmd_ready=1, busy=0, done=0, cmd_err=0; FSM=IDLE; bit_idx=0.
//  Reset mid-frame aborts immediately to reset values; CS rising makes the GPU drop the partial frame.
//  Frame bits (bit 0 sent first): [7:0] cmd, [13:8] color, [20:14] v0_x, [27:21] v1_x, [34:28] v2_x,
//   [40:35] v0_y, [46:41] v1_y, [52:47] v2_y. All inputs are latched into a 53-bit register on accept.
//  FSM: IDLE -> SETUP -> {LOW <-> HIGH} x53 -> HOLD -> GAP -> IDLE.
//   IDLE : on accept: cs_out<=0, mosi_out<=frame[0], bit_idx<=0, -> SETUP.
//   SETUP: CS_SETUP cycles, then -> LOW.
//   LOW  : sck_out=0 for >= HALF_PERIOD cycles; at the end, if window_ok, sck_out<=1 -> HIGH; else stay
//          in LOW (counter saturates) until window_ok. The rising edge is never issued with window_ok low.
//   HIGH : HALF_PERIOD cycles; then sck_out<=0; if bit_idx==52 -> HOLD, else bit_idx++,
//          mosi_out<=frame[bit_idx+1] (mosi changes only on the SCK falling edge) -> LOW.
//   HOLD : HALF_PERIOD cycles sck low, mosi held; then cs_out<=1, mosi_out<=0 -> GAP.
//   GAP  : CS_GAP cycles; done=1 on the last one; -> IDLE (cmd_ready=1 the following cycle).
//  Latency with window_ok=1: done is high exactly CS_SETUP+107*HALF_PERIOD+CS_GAP cycles after the
//   accept edge (434 at defaults). window_ok low only stretches LOW phases; HIGH phases are never cut.
//  window_ok must fall >=3 clk cycles before the GPU closes its load window (frontend sync delay).
//  Exactly 53 SCK rising edges per CS-low window; cmd_valid during busy is ignored (no queue).
// CONFIGURATION
//  SPI_TX_CMD_FILTER_EN defined: on accept, a cmd outside the five codes is not sent: cs_out stays 1,
//   cmd_err pulses the cycle after accept, FSM stays IDLE, done never pulses.
//  Undefined: any cmd byte is transmitted unchanged (GPU ignores unknown codes); cmd_err tied 0.
// STRUCTURE
//  gpu_spi_pkg: command-code constants, FRAME_BITS=53, field LSB/width constants, FSM state encoding —
//   shared with the GPU frontend and the benches.
//  Sub-module tt_um_emern_frame_pack: combinational field -> 53-bit frame packer (reused by bench model).
// TESTING
//  1 Reset: hold rst 3 cycles -> cs_out=1, sck_out=0, mosi_out=0, cmd_ready=1, no SCK edges.
//  2 WR_A color=0x2A v0=(5,7) v1=(100,33) v2=(127,63), loopback into the GPU frontend -> poly_a regs
//    equal the inputs, poly_en[0]=1, exactly 53 SCK rises, done at accept+434.
//  3 window_ok low for 50 cycles after bit 20 -> sck_out stays 0 throughout, no bit lost, frame still
//    decodes; done delayed by the stall length.
//  4 Back-to-back SET_BG 0x15 then CLR_A with cmd_valid held -> second accept 1 cycle after done;
//    cs_out high >= CS_GAP cycles between frames; bg=0x15, poly_en[0]=0.
//  5 rst pulse during bit 30 -> cs_out=1 next cycle; frontend registers unchanged; next frame decodes OK.
//  6 SPI_TX_CMD_FILTER_EN, cmd=0x55 -> cmd_err one pulse, cs_out never low; undefined -> 53 bits sent.

Source files
------------

// File: rtl/gpu_spi_pkg.sv
// Shared GPU command-link definitions: command codes, 53-bit frame layout and SPI TX FSM states.
package gpu_spi_pkg;

   localparam int unsigned FRAME_BITS = 53;

   localparam logic [7:0] CMD_WR_A   = 8'h80;
   localparam logic [7:0] CMD_CLR_A  = 8'h40;
   localparam logic [7:0] CMD_WR_B   = 8'h81;
   localparam logic [7:0] CMD_CLR_B  = 8'h41;
   localparam logic [7:0] CMD_SET_BG = 8'h01;

   localparam int unsigned CMD_LSB   = 0;
   localparam int unsigned CMD_W     = 8;
   localparam int unsigned COLOR_LSB = 8;
   localparam int unsigned COLOR_W   = 6;
   localparam int unsigned V0X_LSB   = 14;
   localparam int unsigned V1X_LSB   = 21;
   localparam int unsigned V2X_LSB   = 28;
   localparam int unsigned VX_W      = 7;
   localparam int unsigned V0Y_LSB   = 35;
   localparam int unsigned V1Y_LSB   = 41;
   localparam int unsigned V2Y_LSB   = 47;
   localparam int unsigned VY_W      = 6;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLow,
      StHigh,
      StHold,
      StGap
   } spi_state_e;

   function automatic logic cmd_is_known(input logic [7:0] c);
      return (c == CMD_WR_A) || (c == CMD_CLR_A) || (c == CMD_WR_B) ||
             (c == CMD_CLR_B) || (c == CMD_SET_BG);
   endfunction

endpackage

// File: rtl/tt_um_emern_frame_pack.sv
// Combinational packer: command byte, colour and three vertices -> 53-bit GPU frame (bit 0 first).
module tt_um_emern_frame_pack
   import gpu_spi_pkg::*;
(
   input  logic [7:0]            cmd_i,
   input  logic [5:0]            color_i,
   input  logic [6:0]            v0_x_i,
   input  logic [6:0]            v1_x_i,
   input  logic [6:0]            v2_x_i,
   input  logic [5:0]            v0_y_i,
   input  logic [5:0]            v1_y_i,
   input  logic [5:0]            v2_y_i,
   output logic [FRAME_BITS-1:0] frame_o
);

   always_comb begin
      frame_o                        = '0;
      frame_o[CMD_LSB   +: CMD_W]    = cmd_i;
      frame_o[COLOR_LSB +: COLOR_W]  = color_i;
      frame_o[V0X_LSB   +: VX_W]     = v0_x_i;
      frame_o[V1X_LSB   +: VX_W]     = v1_x_i;
      frame_o[V2X_LSB   +: VX_W]     = v2_x_i;
      frame_o[V0Y_LSB   +: VY_W]     = v0_y_i;
      frame_o[V1Y_LSB   +: VY_W]     = v1_y_i;
      frame_o[V2Y_LSB   +: VY_W]     = v2_y_i;
   end

endmodule

// File: rtl/tt_um_emern_spi_cmd_tx.sv
// Host-side write-only SPI master (mode 0, LSB first) sending one 53-bit GPU frame per CS-low window.
// Define SPI_TX_CMD_FILTER_EN to reject unknown command bytes with a cmd_err pulse instead of sending.
module tt_um_emern_spi_cmd_tx
   import gpu_spi_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 4,
   parameter int unsigned CS_SETUP    = 2,
   parameter int unsigned CS_GAP      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd,
   input  logic [5:0] color,
   input  logic [6:0] v0_x,
   input  logic [6:0] v1_x,
   input  logic [6:0] v2_x,
   input  logic [5:0] v0_y,
   input  logic [5:0] v1_y,
   input  logic [5:0] v2_y,
   input  logic       window_ok,
   output logic       cs_out,
   output logic       sck_out,
   output logic       mosi_out,
   output logic       busy,
   output logic       done,
   output logic       cmd_err
);

   localparam int unsigned CntMax0 = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
   localparam int unsigned CntMax  = (CntMax0 > CS_GAP) ? CntMax0 : CS_GAP;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] HpLast    = CntW'(HALF_PERIOD - 1);
   localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
   localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
   localparam logic [5:0]      LastBit   = 6'(FRAME_BITS - 1);

   spi_state_e            state_q;
   logic [CntW-1:0]       cnt_q;
   logic [5:0]            bit_idx_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic                  cs_q, sck_q, mosi_q, done_q, cmd_err_q;

   logic [FRAME_BITS-1:0] frame_in;
   logic                  cmd_known;
   logic [5:0]            bit_nxt;

   tt_um_emern_frame_pack u_pack (
      .cmd_i   (cmd),
      .color_i (color),
      .v0_x_i  (v0_x),
      .v1_x_i  (v1_x),
      .v2_x_i  (v2_x),
      .v0_y_i  (v0_y),
      .v1_y_i  (v1_y),
      .v2_y_i  (v2_y),
      .frame_o (frame_in)
   );

`ifdef SPI_TX_CMD_FILTER_EN
   assign cmd_known = cmd_is_known(cmd);
`else
   assign cmd_known = 1'b1;
`endif

   assign bit_nxt = bit_idx_q + 6'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         frame_q   <= '0;
         cs_q      <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cmd_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  if (cmd_known) begin
                     frame_q   <= frame_in;
                     cs_q      <= 1'b0;
                     mosi_q    <= frame_in[0];
                     bit_idx_q <= '0;
                     cnt_q     <= '0;
                     state_q   <= StSetup;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            StSetup: begin
               if (cnt_q == SetupLast) begin
                  cnt_q   <= '0;
                  state_q <= StLow;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StLow: begin
               // Counter saturates so the rise fires on the first cycle window_ok returns.
               if (cnt_q == HpLast) begin
                  if (window_ok) begin
                     sck_q   <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= StHigh;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StHigh: begin
               if (cnt_q == HpLast) begin
                  sck_q <= 1'b0;
                  cnt_q <= '0;
                  if (bit_idx_q == LastBit) begin
                     state_q <= StHold;
                  end else begin
                     bit_idx_q <= bit_nxt;
                     mosi_q    <= frame_q[bit_nxt];
                     state_q   <= StLow;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StHold: begin
               if (cnt_q == HpLast) begin
                  cs_q    <= 1'b1;
                  mosi_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StGap;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  done_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = ~cmd_ready;
   assign cs_out    = cs_q;
   assign sck_out   = sck_q;
   assign mosi_out  = mosi_q;
   assign done      = done_q;
   assign cmd_err   = cmd_err_q;

endmodule
